// File: rtl/add2_seq_ctrl.sv
// add2_seq_ctrl: W-bit adder sequenced over a 2-bit full-adder slice,
// two bits per clock, LSB pair first, with start/abort/busy/done handshake.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start, abort  request a new add / cancel an add in progress
//   a, b, cin     operands, captured on the accepting edge
//   busy, done    RUN / DONE state decodes
//   sum, cout     registered result, carry out of bit W-1
//   ovf           signed overflow of the last completed add
module add2_seq_ctrl #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int N  = W / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  acc;
   logic          c_reg;
   logic [CW-1:0] cnt;

   // 2-bit full-adder slice
   logic          s0;
   logic          s1;
   logic          c1;
   logic          c;
   logic [W-1:0]  acc_nxt;

   assign s0 = a_sh[0] ^ b_sh[0] ^ c_reg;
   assign c1 = (a_sh[0] & b_sh[0]) | (c_reg & (a_sh[0] ^ b_sh[0]));
   assign s1 = a_sh[1] ^ b_sh[1] ^ c1;
   assign c  = (a_sh[1] & b_sh[1]) | (c1 & (a_sh[1] ^ b_sh[1]));

   // New pair enters at the top; after N steps the LSB pair is at bit 0.
   assign acc_nxt = {s1, s0, acc[W-1:2]};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         c_reg <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c_reg <= cin;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  acc   <= acc_nxt;
                  a_sh  <= {2'b00, a_sh[W-1:2]};
                  b_sh  <= {2'b00, b_sh[W-1:2]};
                  c_reg <= c;
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     sum   <= acc_nxt;
                     cout  <= c;
                     // c1 here is the carry into bit W-1
                     ovf   <= c1 ^ c;
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add2_seq_ctrl.sv
// tb_add2_seq_ctrl: self-checking bench for add2_seq_ctrl (W=16),
// scoreboard of expected {cout, ovf, sum} popped when done is seen.
module tb_add2_seq_ctrl;

   localparam int W = 16;
   localparam int N = W / 2;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   logic [W+1:0] exp_q[$];

   add2_seq_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // Independent model: {cout, ovf, sum}
   function automatic logic [W+1:0] model(input logic [W-1:0] ta,
                                          input logic [W-1:0] tb,
                                          input logic tc);
      logic [W:0] full;
      logic       v;
      full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      v = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
      return {full[W], v, full[W-1:0]};
   endfunction

   task automatic check_result(input string tag);
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
         chk({tag, "_cout"}, 32'(cout), 32'(e[W+1]));
         chk({tag, "_ovf"}, 32'(ovf), 32'(e[W]));
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tc);
      int nb;
      int k;
      @(negedge clk);
      a = ta;
      b = tb;
      cin = tc;
      start = 1'b1;
      exp_q.push_back(model(ta, tb, tc));
      @(negedge clk);
      start = 1'b0;
      a = ~ta;
      b = ~tb;
      nb = 0;
      k = 0;
      while (busy && k < 4 * N) begin
         nb++;
         k++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(nb), 32'(N));
      chk({tag, "_done"}, 32'(done), 32'd1);
      check_result(tag);
   endtask

   initial begin
      int done_k[2];
      int nd;
      logic [W-1:0] hold_sum;

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);

      run_op("basic", 16'h1234, 16'h4321, 1'b0);
      run_op("carry1", 16'hFFFF, 16'h0000, 1'b1);
      run_op("carry2", 16'h8000, 16'h8000, 1'b0);
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0);
      // DONE holds the result while start stays low
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
      chk("done_hold_sum", 32'(sum), 32'h8000);

      // start ignored in RUN, abort in RUN cycle 3
      @(negedge clk);
      a = 16'h1111;
      b = 16'h2222;
      cin = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ab_busy1", 32'(busy), 32'd1);
      chk("ab_done1", 32'(done), 32'd0);
      @(negedge clk);
      a = 16'h00AA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      chk("ab_sum", 32'(sum), 32'h8000);
      chk("ab_ovf", 32'(ovf), 32'd1);
      chk("ab_cout", 32'(cout), 32'd0);
      repeat (N + 2) @(negedge clk);
      chk("ab_idle_busy", 32'(busy), 32'd0);
      chk("ab_idle_done", 32'(done), 32'd0);
      chk("ab_idle_sum", 32'(sum), 32'h8000);

      // back-to-back with start held high
      @(negedge clk);
      a = 16'h0003;
      b = 16'h0001;
      cin = 1'b0;
      start = 1'b1;
      exp_q.push_back(model(16'h0003, 16'h0001, 1'b0));
      exp_q.push_back(model(16'h00FF, 16'h0001, 1'b0));
      @(negedge clk);
      a = 16'h00FF;
      b = 16'h0001;
      nd = 0;
      done_k[0] = -1;
      done_k[1] = -1;
      for (int k = 0; k < 4 * N && nd < 2; k++) begin
         if (done) begin
            done_k[nd] = k;
            check_result("b2b");
            nd++;
            if (nd == 2) start = 1'b0;
         end
         if (k == N + 1) chk("b2b_restart", 32'(busy), 32'd1);
         @(negedge clk);
      end
      chk("b2b_ndone", 32'(nd), 32'd2);
      chk("b2b_first", 32'(done_k[0]), 32'(N));
      chk("b2b_spacing", 32'(done_k[1] - done_k[0]), 32'(N + 1));
      @(negedge clk);
      chk("b2b_after", 32'(busy), 32'd0);

      // async reset mid-RUN
      hold_sum = sum;
      chk("pre_rst_sum", 32'(hold_sum), 32'h0100);
      @(negedge clk);
      a = 16'hFFFF;
      b = 16'hFFFF;
      cin = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_sum", 32'(sum), 32'd0);
      chk("mrst_cout", 32'(cout), 32'd0);
      chk("mrst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 2) @(negedge clk);
      chk("mrst_idle_busy", 32'(busy), 32'd0);
      chk("mrst_idle_done", 32'(done), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add2_seq_ctrl.md
Name: add2_seq_ctrl

Overview:
- Sequencer that computes one W-bit add using a single 2-bit full-adder slice (x[1:0], y[1:0], carry-in → 2-bit sum, carry-out), two bits per clock, LSB pair first.
- Owns the operand shift registers, the carry register, the step counter, the result register and the start/busy/done handshake.
- Sits between a requester that supplies wide operands and the area-cheap 2-bit adder datapath.

Parameters:
W, 16, operand/result width in bits; must be even and >= 4; step count N = W/2

Ports:
clk     input   1   rising-edge clock
rst_n   input   1   asynchronous active-low reset
start   input   1   request a new add; sampled only in IDLE or DONE
abort   input   1   cancel the add in progress; sampled only in RUN
a       input   W   operand A; sampled on the accepting edge only
b       input   W   operand B; sampled on the accepting edge only
cin     input   1   carry-in; sampled on the accepting edge only
busy    output  1   high while in RUN
done    output  1   high while in DONE (result valid)
sum     output  W   registered result
cout    output  1   carry out of bit W-1
ovf     output  1   signed overflow = (carry into bit W-1) XOR cout

Behaviour:
- Reset: rst_n=0 asynchronously forces
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - all internal shift, carry and count registers to 0
  - Takes effect immediately, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE. busy and done are decoded directly from state registers, with no combinational path from inputs.
- IDLE or DONE, start=1:
  - load a_sh=a, b_sh=b, c_reg=cin, cnt=0, acc=0
  - next state RUN; done falls on the same edge.
- IDLE or DONE, start=0: hold state.
- abort is ignored in IDLE and DONE.
- RUN, every edge (abort=0):
  - Slice inputs: x=a_sh[1:0], y=b_sh[1:0], c0=c_reg.
  - Slice outputs: s[1:0], internal bit-1 carry-in c1, carry-out c.
  - acc <= {s, acc[W-1:2]}.
  - a_sh and b_sh shift right by 2, zero-filled.
  - c_reg <= c; cnt <= cnt+1.
- RUN, cnt==N-1 (last step):
  - sum <= {s, acc[W-1:2]}, cout <= c, ovf <= c1 ^ c.
  - Next state DONE.
- start is ignored in RUN; operands changing during RUN have no effect.
- RUN, abort=1:
  - Next state IDLE; busy falls.
  - No slice step is taken that cycle.
  - sum, cout and ovf keep their previous values; done stays 0.
- sum, cout and ovf change only on the RUN→DONE edge (or reset). They hold their values through IDLE, RUN and DONE otherwise.
- Latency:
  - If start is sampled at edge E0, busy=1 for exactly N cycles (after E0 through E_N).
  - At edge E_N the result registers update and done rises.
  - Result is valid N cycles after the accepting edge.
- DONE persists until start=1, so back-to-back operation is possible. With start held high, DONE lasts one cycle, giving N+1 cycles per op.
- Arithmetic is modulo 2^W. The full result is {cout, sum} = a + b + cin.

Test Plan:
- Reset (W=16): assert rst_n=0 mid-RUN between edges → busy, done, sum, cout, ovf all 0 immediately. Release, start=0 → stays IDLE.
- Basic add: a=0x1234, b=0x4321, cin=0, one-cycle start → busy high exactly 8 cycles, done rises on 8th edge, sum=0x5555, cout=0, ovf=0.
- Carry chain: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Also a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, ovf=1.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- Ignore/abort, continuing from the previous result sum=0x8000:
  - start a new add; pulse start again in RUN cycle 2 → ignored.
  - abort in RUN cycle 3 → IDLE next edge, done=0, sum still 0x8000, ovf still 1.
- Back-to-back: hold start=1 with a=0x0003/b=0x0001, then a=0x00FF/b=0x0001 → done high one cycle between ops, results 0x0004 then 0x0100, 9-cycle spacing.
